// File: rtl/vram_host_pkg.sv
// Shared constants for the VRAM host command port: opcodes, FSM state codes
// and default geometry/reset values.
package vram_host_pkg;

    localparam int         DEF_VRAM_DEPTH = 24576;
    localparam int         DEF_ADDR_W     = 15;
    localparam logic [2:0] DEF_MODE_RESET = 3'd1;

    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_SET_MODE = 8'h04;
    localparam logic [7:0] OP_FILL     = 8'h05;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ADDR_HI  = 4'd1;
    localparam state_t ST_ADDR_LO  = 4'd2;
    localparam state_t ST_WR_LEN   = 4'd3;
    localparam state_t ST_WR_DATA  = 4'd4;
    localparam state_t ST_RD_LEN   = 4'd5;
    localparam state_t ST_RD_ADDR  = 4'd6;
    localparam state_t ST_RD_WAIT  = 4'd7;
    localparam state_t ST_RD_SEND  = 4'd8;
    localparam state_t ST_MODE_VAL = 4'd9;
    localparam state_t ST_FILL_HI  = 4'd10;
    localparam state_t ST_FILL_LO  = 4'd11;
    localparam state_t ST_FILL_VAL = 4'd12;
    localparam state_t ST_FILL_RUN = 4'd13;

endpackage

// File: rtl/vram_addr_ctr.sv
// Loadable VRAM address pointer that wraps from VRAM_DEPTH-1 back to 0;
// an out-of-range load is flagged and forces the pointer to 0.
module vram_addr_ctr
    import vram_host_pkg::*;
#(
    parameter int VRAM_DEPTH = DEF_VRAM_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] addr_inc_o,
    output logic              load_oor_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Next pointer: load has priority over increment.
    always_comb begin
        load_oor_o = (load_val_i > LAST_ADDR);
        if (addr_q == LAST_ADDR) begin
            addr_inc_o = '0;
        end else begin
            addr_inc_o = addr_q + ADDR_W'(1);
        end
        if (load_i) begin
            if (load_oor_o) begin
                addr_d = '0;
            end else begin
                addr_d = load_val_i;
            end
        end else if (inc_i) begin
            addr_d = addr_inc_o;
        end else begin
            addr_d = addr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/vram_host_port.sv
// Host byte-stream command interpreter driving the VRAM user port and display mode.
// Build option: define VRAM_HOST_FILL_EN to include the FILL (0x05) command.
module vram_host_port
    import vram_host_pkg::*;
#(
    parameter int         VRAM_DEPTH = DEF_VRAM_DEPTH,
    parameter int         ADDR_W     = DEF_ADDR_W,
    parameter logic [2:0] MODE_RESET = DEF_MODE_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    input  logic [7:0]        vram_rdata,
    output logic [2:0]        mode,
    output logic              busy,
    output logic              cmd_err
);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [6:0]        addr_hi_q, addr_hi_d;
    logic              rx_ready_q, rx_ready_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]        vram_wdata_q, vram_wdata_d;
    logic              vram_we_q, vram_we_d;
    logic [2:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;
`ifdef VRAM_HOST_FILL_EN
    logic [7:0]        fill_val_q, fill_val_d;
`endif

    logic              accept_s;
    logic              ptr_load_s;
    logic              ptr_inc_s;
    logic [ADDR_W-1:0] ptr_load_val_s;
    logic [ADDR_W-1:0] ptr_s;
    logic [ADDR_W-1:0] ptr_next_s;
    logic              ptr_oor_s;

    assign accept_s       = rx_valid & rx_ready_q;
    assign ptr_load_val_s = ADDR_W'({addr_hi_q, rx_data});

    vram_addr_ctr #(
        .VRAM_DEPTH (VRAM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ptr_load_s),
        .load_val_i (ptr_load_val_s),
        .inc_i      (ptr_inc_s),
        .addr_o     (ptr_s),
        .addr_inc_o (ptr_next_s),
        .load_oor_o (ptr_oor_s)
    );

    // Command FSM and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_hi_d    = addr_hi_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        vram_we_d    = 1'b0;
        mode_d       = mode_q;
        cmd_err_d    = 1'b0;
        ptr_load_s   = 1'b0;
        ptr_inc_s    = 1'b0;
`ifdef VRAM_HOST_FILL_EN
        fill_val_d   = fill_val_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (rx_data)
                        OP_SET_ADDR: state_d = ST_ADDR_HI;
                        OP_WRITE:    state_d = ST_WR_LEN;
                        OP_READ:     state_d = ST_RD_LEN;
                        OP_SET_MODE: state_d = ST_MODE_VAL;
`ifdef VRAM_HOST_FILL_EN
                        OP_FILL:     state_d = ST_FILL_HI;
`endif
                        default:     cmd_err_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_HI: begin
                if (accept_s) begin
                    addr_hi_d = rx_data[6:0];
                    state_d   = ST_ADDR_LO;
                end else begin
                    state_d = ST_ADDR_HI;
                end
            end
            ST_ADDR_LO: begin
                if (accept_s) begin
                    ptr_load_s = 1'b1;
                    cmd_err_d  = ptr_oor_s;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_ADDR_LO;
                end
            end
            ST_WR_LEN: begin
                if (accept_s) begin
                    cnt_d   = (rx_data == 8'd0) ? 16'd256 : {8'd0, rx_data};
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_LEN;
                end
            end
            ST_WR_DATA: begin
                if (accept_s) begin
                    vram_we_d    = 1'b1;
                    vram_addr_d  = ptr_s;
                    vram_wdata_d = rx_data;
                    ptr_inc_s    = 1'b1;
                    cnt_d        = cnt_q - 16'd1;
                    state_d      = (cnt_q == 16'd1) ? ST_IDLE : ST_WR_DATA;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_LEN: begin
                if (accept_s) begin
                    cnt_d       = (rx_data == 8'd0) ? 16'd256 : {8'd0, rx_data};
                    vram_addr_d = ptr_s;
                    state_d     = ST_RD_ADDR;
                end else begin
                    state_d = ST_RD_LEN;
                end
            end
            // The address is already on the port here; VRAM answers next cycle.
            ST_RD_ADDR: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                tx_data_d  = vram_rdata;
                tx_valid_d = 1'b1;
                state_d    = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (tx_ready) begin
                    tx_valid_d  = 1'b0;
                    ptr_inc_s   = 1'b1;
                    vram_addr_d = ptr_next_s;
                    cnt_d       = cnt_q - 16'd1;
                    state_d     = (cnt_q == 16'd1) ? ST_IDLE : ST_RD_ADDR;
                end else begin
                    state_d = ST_RD_SEND;
                end
            end
            ST_MODE_VAL: begin
                if (accept_s) begin
                    mode_d  = rx_data[2:0];
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MODE_VAL;
                end
            end
`ifdef VRAM_HOST_FILL_EN
            ST_FILL_HI: begin
                if (accept_s) begin
                    cnt_d   = {rx_data, cnt_q[7:0]};
                    state_d = ST_FILL_LO;
                end else begin
                    state_d = ST_FILL_HI;
                end
            end
            ST_FILL_LO: begin
                if (accept_s) begin
                    cnt_d   = {cnt_q[15:8], rx_data};
                    state_d = ST_FILL_VAL;
                end else begin
                    state_d = ST_FILL_LO;
                end
            end
            ST_FILL_VAL: begin
                if (accept_s) begin
                    fill_val_d = rx_data;
                    state_d    = (cnt_q == 16'd0) ? ST_IDLE : ST_FILL_RUN;
                end else begin
                    state_d = ST_FILL_VAL;
                end
            end
            ST_FILL_RUN: begin
                vram_we_d    = 1'b1;
                vram_addr_d  = ptr_s;
                vram_wdata_d = fill_val_q;
                ptr_inc_s    = 1'b1;
                cnt_d        = cnt_q - 16'd1;
                state_d      = (cnt_q == 16'd1) ? ST_IDLE : ST_FILL_RUN;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d     = (state_d != ST_IDLE);
        rx_ready_d = !((state_d == ST_RD_ADDR) || (state_d == ST_RD_WAIT) ||
                       (state_d == ST_RD_SEND) || (state_d == ST_FILL_RUN));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            addr_hi_q    <= 7'd0;
            rx_ready_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= 8'd0;
            vram_we_q    <= 1'b0;
            mode_q       <= MODE_RESET;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
`ifdef VRAM_HOST_FILL_EN
            fill_val_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_hi_q    <= addr_hi_d;
            rx_ready_q   <= rx_ready_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            vram_we_q    <= vram_we_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
`ifdef VRAM_HOST_FILL_EN
            fill_val_q   <= fill_val_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_we    = vram_we_q;
    assign mode       = mode_q;
    assign busy       = busy_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_vram_host_port.sv
// Scoreboard bench for vram_host_port: expected VRAM writes and read-back
// bytes are queued by the stimulus and popped by a negedge monitor.
module tb_vram_host_port;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [14:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata = 8'd0;
    logic [2:0]  mode;
    logic        busy;
    logic        cmd_err;

    logic [7:0]  mem [0:24575];

    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_we_cyc = -10;
    int          we_run = 0;
    int          tx_count = 0;
    int          cmd_err_cnt = 0;
    int          exp_err = 0;

    vram_host_port dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_rdata (vram_rdata),
        .mode       (mode),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read VRAM model: data appears one cycle after the address.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every write and every tx handshake against the queues.
    always @(negedge clk) begin
        wr_t e;
        logic [7:0] t;
        cyc++;
        if (vram_we === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%0h", vram_addr, vram_wdata);
            end else begin
                e = exp_wr.pop_front();
                if (vram_addr !== e.addr || vram_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             vram_addr, vram_wdata, e.addr, e.data);
                end
            end
            we_run = (last_we_cyc == cyc - 1) ? we_run + 1 : 1;
            last_we_cyc = cyc;
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx: data=%0h", tx_data);
            end else begin
                t = exp_tx.pop_front();
                if (tx_data !== t) begin
                    errors++;
                    $display("FAIL tx_data: got %0h expected %0h", tx_data, t);
                end
            end
            tx_count++;
        end
        if (cmd_err === 1'b1) cmd_err_cnt++;
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [14:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n;
        logic bad;

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_vram_addr", 32'(vram_addr), 32'd0);
        chk("rst_vram_wdata", 32'(vram_wdata), 32'd0);
        chk("rst_vram_we", 32'(vram_we), 32'd0);
        chk("rst_mode", 32'(mode), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // WRITE 3 bytes at 0x10 back-to-back
        push_wr(15'h0010, 8'hAA);
        push_wr(15'h0011, 8'hBB);
        push_wr(15'h0012, 8'hCC);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        @(negedge clk);
        chk("write_run3", 32'(we_run), 32'd3);
        chk("busy_after_write", 32'(busy), 32'd0);

        // WRITE across the wrap point
        push_wr(15'd24575, 8'h11);
        push_wr(15'd0, 8'h22);
        send_byte(8'h01); send_byte(8'h5F); send_byte(8'hFF);
        send_byte(8'h02); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        chk("wrap_run2", 32'(we_run), 32'd2);

        // READ 3 bytes with a 5-cycle stall on byte 2
        exp_tx.push_back(8'hAA);
        exp_tx.push_back(8'hBB);
        exp_tx.push_back(8'hCC);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h03); send_byte(8'h03);
        bad = 1'b0;
        n = 0;
        while (tx_count < 1 && n < 50) begin
            if (rx_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("rd_byte1_timeout", 32'(n < 50), 32'd1);
        chk("rd_rx_ready_low", 32'(bad), 32'd0);
        @(posedge clk); #1 tx_ready = 1'b0;
        @(negedge clk);
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_byte2_timeout", 32'(n < 50), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'hBB || rx_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("rd_stall_hold", 32'(bad), 32'd0);
        chk("rd_stall_count", 32'(tx_count), 32'd1);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (tx_count < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_done_timeout", 32'(n < 50), 32'd1);
        wait_idle("rd_idle_timeout");
        @(negedge clk);
        chk("rx_ready_after_read", 32'(rx_ready), 32'd1);

        // SET_MODE ignores upper bits
        send_byte(8'h04); send_byte(8'hFA);
        chk("mode_fa", 32'(mode), 32'd2);

        // Unknown opcode
        exp_err++;
        send_byte(8'h7E);
        @(negedge clk);
        chk("err_unknown_op", 32'(cmd_err_cnt), 32'(exp_err));
        chk("idle_after_unknown", 32'(busy), 32'd0);

        // Out-of-range address forces pointer to 0
        exp_err++;
        send_byte(8'h01); send_byte(8'h7F); send_byte(8'hFF);
        @(negedge clk);
        chk("err_addr_oor", 32'(cmd_err_cnt), 32'(exp_err));
        push_wr(15'd0, 8'h77);
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h77);
        @(negedge clk);

`ifdef VRAM_HOST_FILL_EN
        push_wr(15'd0, 8'h55);
        push_wr(15'd1, 8'h55);
        push_wr(15'd2, 8'h55);
        push_wr(15'd3, 8'h55);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h04); send_byte(8'h55);
        wait_idle("fill_timeout");
        @(negedge clk);
        chk("fill_run4", 32'(we_run), 32'd4);
        chk("fill_no_err", 32'(cmd_err_cnt), 32'(exp_err));
`else
        exp_err++;
        send_byte(8'h05);
        @(negedge clk);
        chk("err_fill_disabled", 32'(cmd_err_cnt), 32'(exp_err));
`endif
        send_byte(8'h04); send_byte(8'h03);
        chk("mode_03", 32'(mode), 32'd3);

        // Reset in the middle of a 4-byte WRITE
        push_wr(15'h0020, 8'h01);
        push_wr(15'h0021, 8'h02);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h02); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_mode", 32'(mode), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_vram_addr", 32'(vram_addr), 32'd0);
        chk("midrst_vram_we", 32'(vram_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rx_ready_back", 32'(rx_ready), 32'd1);
        send_byte(8'h04); send_byte(8'h02);
        chk("mode_after_midrst", 32'(mode), 32'd2);
        repeat (3) @(negedge clk);

        chk("mem_wrap_last", 32'(mem[24575]), 32'h11);
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);
        chk("pending_tx", 32'(exp_tx.size()), 32'd0);
        chk("cmd_err_total", 32'(cmd_err_cnt), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
